// File: rtl/generador_tiempo_muerto.sv
// -----------------------------------------------------------------------------
// generador_tiempo_muerto
// Dead-time generator for one full-bridge leg. The raw switching command is
// synchronized, then an FSM drives complementary high/low gate signals with a
// guaranteed dead time between one gate turning off and the other turning on.
// A command that reverts before the dead time expires aborts the transition
// and is flagged on pulso_suprimido.
//
// Optional build macro:
//   DEADTIME_PROG_EN : adds input tiempo_muerto[7:0], which replaces
//                      DEAD_CYCLES; sampled when the dead-time counter loads,
//                      0 is treated as 1.
//
// Ports:
//   clk_100MHz      in   system clock
//   rst             in   asynchronous reset, active low
//   enable          in   0 forces both gates off
//   in_conmutacion  in   raw switching command (asynchronous)
//   tiempo_muerto   in   [7:0] dead time in cycles (DEADTIME_PROG_EN only)
//   gate_alto       out  high-side gate, registered
//   gate_bajo       out  low-side gate, registered
//   pulso_suprimido out  one-cycle flag for an aborted transition
//
// State table:
//   APAGADO       | bridge disabled, both gates off
//   MUERTO_A_ALTO | dead time before turning the high side on
//   ALTO          | high side on
//   MUERTO_A_BAJO | dead time before turning the low side on
//   BAJO          | low side on
// -----------------------------------------------------------------------------
module generador_tiempo_muerto #(
    parameter int unsigned DEAD_CYCLES = 50
) (
    input  logic       clk_100MHz,
    input  logic       rst,
    input  logic       enable,
    input  logic       in_conmutacion,
`ifdef DEADTIME_PROG_EN
    input  logic [7:0] tiempo_muerto,
`endif
    output logic       gate_alto,
    output logic       gate_bajo,
    output logic       pulso_suprimido
);

    typedef enum logic [2:0] {
        APAGADO,
        MUERTO_A_ALTO,
        ALTO,
        MUERTO_A_BAJO,
        BAJO
    } estado_t;

    localparam logic [7:0] CARGA_FIJA = 8'(DEAD_CYCLES - 1);

    logic       sync_1;
    logic       s;
    estado_t    estado;
    estado_t    estado_sig;
    logic [7:0] contador;
    logic [7:0] contador_sig;
    logic [7:0] carga;
    logic       pulso_sig;

    // Counter load value: the MUERTO state lasts carga+1 cycles.
`ifdef DEADTIME_PROG_EN
    assign carga = (tiempo_muerto == 8'd0) ? 8'd0 : tiempo_muerto - 8'd1;
`else
    assign carga = CARGA_FIJA;
`endif

    always_ff @(posedge clk_100MHz or negedge rst) begin
        if (!rst) begin
            sync_1 <= 1'b0;
            s      <= 1'b0;
        end else begin
            sync_1 <= in_conmutacion;
            s      <= sync_1;
        end
    end

    always_ff @(posedge clk_100MHz or negedge rst) begin
        if (!rst) begin
            estado          <= APAGADO;
            contador        <= 8'd0;
            gate_alto       <= 1'b0;
            gate_bajo       <= 1'b0;
            pulso_suprimido <= 1'b0;
        end else begin
            estado          <= estado_sig;
            contador        <= contador_sig;
            // Gates are decoded from the next state so that they are
            // registered yet change on the same edge as the state.
            gate_alto       <= (estado_sig == ALTO);
            gate_bajo       <= (estado_sig == BAJO);
            pulso_suprimido <= pulso_sig;
        end
    end

    always_comb begin
        estado_sig   = estado;
        contador_sig = 8'd0;
        pulso_sig    = 1'b0;
        if (!enable) begin
            estado_sig = APAGADO;
        end else begin
            case (estado)
                APAGADO: begin
                    estado_sig   = s ? MUERTO_A_ALTO : MUERTO_A_BAJO;
                    contador_sig = carga;
                end
                ALTO: begin
                    if (!s) begin
                        estado_sig   = MUERTO_A_BAJO;
                        contador_sig = carga;
                    end
                end
                BAJO: begin
                    if (s) begin
                        estado_sig   = MUERTO_A_ALTO;
                        contador_sig = carga;
                    end
                end
                // A reverting command wins over expiry, so the leg never
                // turns on a side the command no longer asks for.
                MUERTO_A_ALTO: begin
                    if (!s) begin
                        estado_sig = BAJO;
                        pulso_sig  = 1'b1;
                    end else if (contador == 8'd0) begin
                        estado_sig = ALTO;
                    end else begin
                        contador_sig = contador - 8'd1;
                    end
                end
                MUERTO_A_BAJO: begin
                    if (s) begin
                        estado_sig = ALTO;
                        pulso_sig  = 1'b1;
                    end else if (contador == 8'd0) begin
                        estado_sig = BAJO;
                    end else begin
                        contador_sig = contador - 8'd1;
                    end
                end
                default: estado_sig = APAGADO;
            endcase
        end
    end

endmodule

// File: doc/generador_tiempo_muerto.md
GENERADOR_TIEMPO_MUERTO -- requirements
Module: generador_tiempo_muerto

Interface
REQ-001 Parameter DEAD_CYCLES, default 50, SHALL set the dead time in clk_100MHz cycles; legal range 1..255.
REQ-002 clk_100MHz  input  1  SHALL be the single system clock; all state changes on its rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 enable  input  1  SHALL gate the bridge; 0 forces both gates off.
REQ-005 in_conmutacion  input  1  SHALL be the raw switching signal from the output distribution stage (full-bridge leg), asynchronous to clk_100MHz.
REQ-006 gate_alto  output  1  SHALL drive the high-side switch, active-high, registered.
REQ-007 gate_bajo  output  1  SHALL drive the low-side switch, active-high, registered.
REQ-008 pulso_suprimido  output  1  SHALL be a one-cycle flag marking an aborted transition.

Function
REQ-009 in_conmutacion SHALL pass through a 2-flop synchronizer; s denotes the second flop's output.
REQ-010 FSM states SHALL be APAGADO, MUERTO_A_ALTO, ALTO, MUERTO_A_BAJO, BAJO.
REQ-011 Outputs per state SHALL be: ALTO -> gate_alto=1, gate_bajo=0; BAJO -> gate_alto=0, gate_bajo=1; all others -> both 0.
REQ-012 gate_alto and gate_bajo SHALL never be 1 in the same cycle, under any input sequence.
REQ-013 APAGADO with enable=1 SHALL go to MUERTO_A_ALTO if s=1, else MUERTO_A_BAJO.
REQ-014 BAJO with s=1 SHALL go to MUERTO_A_ALTO; ALTO with s=0 SHALL go to MUERTO_A_BAJO.
REQ-015 Entering a MUERTO state SHALL load an 8-bit down-counter with DEAD_CYCLES-1; the state SHALL last exactly DEAD_CYCLES cycles before moving to ALTO/BAJO respectively.
REQ-016 In MUERTO_A_ALTO with s=0 (or MUERTO_A_BAJO with s=1) before expiry, the FSM SHALL return to BAJO (resp. ALTO) next cycle and assert pulso_suprimido for exactly that one cycle.
REQ-017 enable=0 in any state SHALL move to APAGADO on the next edge, overriding all other transitions; enable has priority over s on the same edge.
REQ-018 Latency from an in_conmutacion edge to the opposite gate turning off SHALL be 3 cycles (2 sync + 1 registered output); the newly enabled gate SHALL rise DEAD_CYCLES cycles later.
REQ-019 The counter SHALL not wrap; it holds 0 outside MUERTO states.

Reset
REQ-020 rst=0 SHALL immediately force gate_alto=0, gate_bajo=0, pulso_suprimido=0, synchronizer flops=0, counter=0, state=APAGADO.
REQ-021 Reset release SHALL take effect on the first clk_100MHz edge with rst=1; from APAGADO the block restarts per REQ-013 with full dead time, even if asserted mid-transition.

Configuration
REQ-022 With macro DEADTIME_PROG_EN defined, an added input tiempo_muerto[7:0] SHALL replace DEAD_CYCLES and SHALL be sampled only when the counter is loaded; value 0 SHALL be treated as 1.
REQ-023 Without DEADTIME_PROG_EN, port tiempo_muerto SHALL not exist and dead time SHALL be the constant DEAD_CYCLES.

Verification
REQ-024 Reset, enable=1, in=0 held -> both gates 0 for 50 cycles after APAGADO exit, then gate_bajo=1.
REQ-025 In BAJO, in 0->1 -> gate_bajo falls 3 cycles later, gate_alto rises 50 cycles after that; overlap never observed.
REQ-026 In BAJO, 20-cycle high pulse on in -> gate_alto never asserts, pulso_suprimido pulses once, gate_bajo returns.
REQ-027 In ALTO, enable 1->0 -> both gates 0 next cycle; enable back to 1 -> full 50-cycle dead time before any gate.
REQ-028 rst=0 asserted during MUERTO_A_ALTO at counter=10 -> outputs 0 without a clock edge; restart obeys REQ-021.
REQ-029 DEADTIME_PROG_EN defined, tiempo_muerto=5 then 0 -> dead times of 5 and 1 cycles respectively.
